reg_file_ctx: RTL and testbench

Parametrised CPU general-purpose register file: NREG registers of WIDTH bits, two combinational read ports (source, destination), one write port and optional write-through forwarding. It adds a shadow bank with a sequenced save/restore engine that copies one register per clock. This lets the control unit checkpoint and recover the full register context around interrupts or traps. It sits between the instruction decoder (sr/dr selects), the ALU (s/d operands, i result) and the control unit (save/restore handshake).

---
 rtl/reg_file_ctx.sv | 143 ++++++++++++++
 tb/tb_reg_file_ctx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ctx.sv
// reg_file_ctx: general-purpose register file with a shadow bank and a
// sequenced save/restore engine that copies one register per clock.
//
// All state updates happen on the falling edge of clk. rst is asynchronous
// and active-high.
//
// Parameters:
//   WIDTH   register width in bits
//   NREG    number of registers (>= 2)
//   BYPASS  1 = read ports forward i while a write to that index is pending
// Ports:
//   clk, rst        clock (falling-edge active), async reset
//   we, dr, i       write enable, destination select, write data
//   sr              source select
//   s, d            combinational contents of R[sr], R[dr]
//   save, restore   request live->shadow or shadow->live copy
//   busy            copy sequence in progress
//   done            one-cycle pulse when a sequence finishes
module reg_file_ctx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREG   = 4,
  parameter int unsigned BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  sr,
  input  logic [$clog2(NREG)-1:0]  dr,
  input  logic [WIDTH-1:0]         i,
  output logic [WIDTH-1:0]         s,
  output logic [WIDTH-1:0]         d,
  input  logic                     save,
  input  logic                     restore,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {StIdle, StSave, StRestore} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic [WIDTH-1:0] regs_q   [NREG];
  logic [WIDTH-1:0] shadow_q [NREG];

  logic write_en;
  logic save_step;
  logic restore_step;

  assign busy = (state_q != StIdle);
  assign done = done_q;

  // Writes land only in IDLE; out-of-range indices are dropped.
  assign write_en     = we && (state_q == StIdle) && (32'(dr) < NREG);
  assign save_step    = (state_q == StSave);
  assign restore_step = (state_q == StRestore);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // save wins over a simultaneous restore
        if (save) begin
          state_d = StSave;
          idx_d   = '0;
        end else if (restore) begin
          state_d = StRestore;
          idx_d   = '0;
        end
      end
      StSave, StRestore: begin
        if (idx_q == AW'(NREG - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Live bank: normal writes in IDLE, restore copies one entry per edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NREG); k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NREG); k++) begin
        if (write_en && (32'(dr) == 32'(k))) begin
          regs_q[k] <= i;
        end else if (restore_step && (32'(idx_q) == 32'(k))) begin
          regs_q[k] <= shadow_q[k];
        end
      end
    end
  end

  // Shadow bank: reset clears it entirely, so an aborted save leaves no
  // partial snapshot behind.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NREG); k++) shadow_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NREG); k++) begin
        if (save_step && (32'(idx_q) == 32'(k))) begin
          shadow_q[k] <= regs_q[k];
        end
      end
    end
  end

  // Read ports; indices >= NREG read as zero.
  always_comb begin
    s = '0;
    d = '0;
    for (int k = 0; k < int'(NREG); k++) begin
      if (32'(sr) == 32'(k)) s = regs_q[k];
      if (32'(dr) == 32'(k)) d = regs_q[k];
    end
    if ((BYPASS != 0) && we && !busy) begin
      if (dr == sr) s = i;
      d = i;
    end
  end

endmodule

// File: tb/tb_reg_file_ctx.sv
// Testbench for reg_file_ctx (WIDTH=8, NREG=4). Two instances share stimulus:
// dut without forwarding and dut_b with forwarding enabled.
module tb_reg_file_ctx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREG  = 4;

  logic             clk = 1'b1;
  logic             rst;
  logic             we;
  logic [1:0]       sr, dr;
  logic [WIDTH-1:0] i;
  logic             save, restore;
  logic [WIDTH-1:0] s, d, s_b, d_b;
  logic             busy, done, busy_b, done_b;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  reg_file_ctx #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .we(we), .sr(sr), .dr(dr), .i(i), .s(s), .d(d),
    .save(save), .restore(restore), .busy(busy), .done(done)
  );

  reg_file_ctx #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .sr(sr), .dr(dr), .i(i), .s(s_b), .d(d_b),
    .save(save), .restore(restore), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic             we;
    logic [1:0]       dr;
    logic [1:0]       sr;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] pre_s;   // forwarding instance, before the edge
    logic [WIDTH-1:0] pre_d;
    logic [WIDTH-1:0] post_s;  // plain instance, after the edge
    logic [WIDTH-1:0] post_d;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance past one falling edge; land just after the following rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input int k, input logic [WIDTH-1:0] exp);
    step();
    sr = 2'(k);
    dr = 2'(k);
    #1;
    chk({name, " s"}, 32'(s), 32'(exp));
    chk({name, " d"}, 32'(d), 32'(exp));
  endtask

  task automatic wr(input int k, input logic [WIDTH-1:0] v);
    we = 1'b1;
    dr = 2'(k);
    i  = v;
    step();
    we = 1'b0;
  endtask

  // Called just after the request edge E0.
  task automatic run_seq(input string name);
    for (int k = 0; k < int'(NREG); k++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " done low"}, 32'(done), 32'd0);
      step();
    end
    we = 1'b0;
    chk({name, " busy end"}, 32'(busy), 32'd0);
    chk({name, " done"}, 32'(done), 32'd1);
    step();
    chk({name, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd2, 2'd2, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 2'd0, 2'd2, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[2] = '{1'b0, 2'd1, 2'd0, 8'hFF, 8'h3C, 8'h00, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 2'd3, 2'd1, 8'hC3, 8'h00, 8'hC3, 8'h00, 8'hC3};
    vecs[4] = '{1'b1, 2'd2, 2'd3, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
    vecs[5] = '{1'b0, 2'd2, 2'd0, 8'h00, 8'h3C, 8'h5A, 8'h3C, 8'h5A};

    rst = 1'b1; we = 1'b0; sr = '0; dr = '0; i = '0; save = 1'b0; restore = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        sr = 2'(a);
        dr = 2'(b);
        #1;
        chk("reset s", 32'(s), 32'd0);
        chk("reset d", 32'(d), 32'd0);
      end
      step();
    end

    // Write/read table
    we = 1'b1; dr = 2'd2; sr = 2'd2; i = 8'hA5;
    #1;
    chk("no bypass pre-edge s", 32'(s), 32'h00);
    for (int j = 0; j < 6; j++) begin
      we = vecs[j].we; dr = vecs[j].dr; sr = vecs[j].sr; i = vecs[j].i;
      #1;
      chk($sformatf("vec%0d bypass s", j), 32'(s_b), 32'(vecs[j].pre_s));
      chk($sformatf("vec%0d bypass d", j), 32'(d_b), 32'(vecs[j].pre_d));
      step();
      chk($sformatf("vec%0d s", j), 32'(s), 32'(vecs[j].post_s));
      chk($sformatf("vec%0d d", j), 32'(d), 32'(vecs[j].post_d));
    end
    we = 1'b0;

    // Save/restore round trip
    for (int k = 0; k < 4; k++) wr(k, 8'(k + 1));
    save = 1'b1;
    step();
    save = 1'b0;
    run_seq("save1");
    for (int k = 0; k < 4; k++) wr(k, 8'hFF);
    rd_chk("overwrite", 2, 8'hFF);
    restore = 1'b1;
    step();
    restore = 1'b0;
    run_seq("restore1");
    for (int k = 0; k < 4; k++) rd_chk($sformatf("rt R%0d", k), k, 8'(k + 1));

    // Write blocked while busy
    save = 1'b1;
    step();
    save = 1'b0;
    we = 1'b1; dr = 2'd0; sr = 2'd0; i = 8'h55;
    #1;
    chk("busy no bypass d", 32'(d_b), 32'h01);
    run_seq("save2");
    rd_chk("blocked R0", 0, 8'h01);
    wr(0, 8'hAA);
    rd_chk("R0 after idle write", 0, 8'hAA);
    restore = 1'b1;
    step();
    restore = 1'b0;
    run_seq("restore2");
    rd_chk("blocked restore R0", 0, 8'h01);

    // Simultaneous save+restore+write on one edge
    save = 1'b1; restore = 1'b1; we = 1'b1; dr = 2'd1; i = 8'h77;
    step();
    save = 1'b0; restore = 1'b0; we = 1'b0;
    run_seq("save3");
    wr(1, 8'h00);
    rd_chk("R1 cleared", 1, 8'h00);
    restore = 1'b1;
    step();
    restore = 1'b0;
    run_seq("restore3");
    rd_chk("snap R1", 1, 8'h77);
    rd_chk("snap R0", 0, 8'h01);

    // Reset during SAVE
    save = 1'b1;
    step();
    save = 1'b0;
    step();
    step();
    chk("mid busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    sr = 2'd1;
    #1;
    chk("rst busy drop", 32'(busy), 32'd0);
    chk("rst done low", 32'(done), 32'd0);
    chk("rst live R1", 32'(s), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("no done after rst", 32'(done), 32'd0);
    end
    restore = 1'b1;
    step();
    restore = 1'b0;
    run_seq("restore4");
    for (int k = 0; k < 4; k++) rd_chk($sformatf("zero R%0d", k), k, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
